// File: rtl/gcd_operand_pairer.sv
// Packs consecutive 16-bit operands into {a, b} GCD requests, buffered in a small FIFO.
// Optional GCD_PAIRER_ORDER_EN orders each pair as {max, min} before it is queued.
module gcd_operand_pairer #(
  parameter int unsigned p_depth = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        istream_val,
  output logic        istream_rdy,
  input  logic [15:0] istream_msg,
  output logic        ostream_val,
  input  logic        ostream_rdy,
  output logic [31:0] ostream_msg
);

  localparam int unsigned PtrW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CntW = $clog2(p_depth + 1);

  localparam logic StEmpty = 1'b0;
  localparam logic StHalf  = 1'b1;

  logic            state_q, state_d;
  logic [15:0]     a_q;
  logic [31:0]     mem [p_depth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic        queue_full;
  logic        queue_empty;
  logic        in_xfer;
  logic        enq;
  logic        deq;
  logic [31:0] pair;

  assign queue_full  = (count_q == CntW'(p_depth));
  assign queue_empty = (count_q == '0);

  // Depends on registered state only, so there is no path from ostream_rdy.
  assign istream_rdy = !((state_q == StHalf) && queue_full);
  assign ostream_val = !queue_empty;
  assign ostream_msg = mem[head_q];

  assign in_xfer = istream_val & istream_rdy;
  assign enq     = in_xfer & (state_q == StHalf);
  assign deq     = ostream_val & ostream_rdy;

`ifdef GCD_PAIRER_ORDER_EN
  always_comb begin
    if (a_q < istream_msg) pair = {istream_msg, a_q};
    else                   pair = {a_q, istream_msg};
  end
`else
  assign pair = {a_q, istream_msg};
`endif

  always_comb begin
    state_d = state_q;
    if (in_xfer) state_d = (state_q == StEmpty) ? StHalf : StEmpty;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (deq) head_d = (head_q == PtrW'(p_depth - 1)) ? '0 : head_q + 1'b1;
    if (enq) tail_d = (tail_q == PtrW'(p_depth - 1)) ? '0 : tail_q + 1'b1;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Data storage carries no reset; validity is tracked by state and count.
  always_ff @(posedge clk) begin
    if (in_xfer && (state_q == StEmpty)) a_q <= istream_msg;
    if (enq) mem[tail_q] <= pair;
  end

endmodule

// File: doc/gcd_operand_pairer.md
# gcd_operand_pairer

Upstream feeder for `hw_gcd_GcdUnit`. It consumes a stream of 16-bit operands and packs each consecutive pair into one 32-bit `{a, b}` request. It buffers completed requests in a small output queue so the GCD unit's long iterations do not stall the producer. It sits between the operand source and the GCD unit's `istream`.

## Interface
- `p_depth`, default 2: output queue entries; legal values 1–8.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `istream.val`  in  1: an operand is valid.
- `istream.rdy`  out  1: the block accepts an operand this cycle.
- `istream.msg`  in  16: operand value.
- `ostream.val`  out  1: a packed request is valid.
- `ostream.rdy`  in  1: the downstream consumer (GCD unit) accepts the request.
- `ostream.msg`  out  32: packed request; `[31:16]` = a, `[15:0]` = b.
- Both streams are `StreamIntf` instances; `istream` is the consumer side and `ostream` is the producer side.

## Operation
- Pairing FSM has two states.
  - `EMPTY`: no operand is held.
  - `HALF`: operand a is held in `a_reg`.
- `EMPTY`, input transfer: capture `istream.msg` into `a_reg`; go to `HALF`.
- `HALF`, input transfer: enqueue `{a_reg, istream.msg}`; go to `EMPTY`.
- Input transfer = `istream.val & istream.rdy`. Output transfer = `ostream.val & ostream.rdy`.
- `istream.rdy = !(state == HALF && queue_full)`. There is no combinational path from `ostream.rdy` to `istream.rdy`.
- Output queue:
  - Circular FIFO of `p_depth` × 32 bits, with head and tail pointers and an occupancy counter of `$clog2(p_depth+1)` bits.
  - Pointers wrap from `p_depth-1` to 0.
  - `ostream.val = !queue_empty`; `ostream.msg = mem[head]`.
- Simultaneous enqueue and dequeue with the queue non-full and non-empty: both happen, occupancy unchanged.
- Enqueue into an empty queue while `ostream.rdy` is high: the new entry does not bypass; it appears on the next cycle.
- Queue full with `ostream.rdy` high: the dequeue happens, but `istream.rdy` stays low that cycle because of the full-state term; the input resumes on the next cycle.
- `istream.msg` is ignored when no input transfer occurs.
- Reset (asserted at any time, including mid-pair):
  - state = `EMPTY`; a held operand is discarded.
  - Queue emptied; pointers and count = 0.
  - `ostream.val = 0`; `istream.rdy = 1`.
  - `a_reg` and `mem` need no reset.

## Timing
- Latency: second operand accepted at edge N → `ostream.val` high, with its packed message, from N until the consumer takes it.
- Throughput: one request every 2 cycles when not backpressured; the input accepts one operand per cycle.
- A request is held stable on `ostream.msg` while `ostream.val & !ostream.rdy`.
- Requests leave in FIFO order; no request is ever dropped or duplicated.
- Asynchronous reset takes effect immediately; the first input transfer can occur on the first rising edge after `rst` deasserts.

## Configuration
- Macro: `GCD_PAIRER_ORDER_EN`.
- Defined:
  - Before enqueue, the pair is ordered as `{max(a, b), min(a, b)}` using a 16-bit unsigned compare.
  - Equal operands are unchanged.
  - This saves the GCD unit an initial swap iteration.
- Undefined: the message is `{first, second}` exactly as received.
- Every other behaviour is identical with or without the macro.

## Test plan
- Basic: send 15, then 5 → one request `0x000F_0005`. With `GCD_PAIRER_ORDER_EN` it is the same; a→b order is already max/min.
- Ordering: send 3, 9 → `0x0003_0009` without the macro, `0x0009_0003` with it. Send 0, 0 → `0x0000_0000` in both builds.
- Backpressure, `p_depth = 2`, `ostream.rdy` held low: send 1, 2, 3, 4, 5, 6. Required response:
  - `istream.rdy` drops after 5 is accepted, with two requests queued and 5 held.
  - Then release `ostream.rdy` → `0x0001_0002`, `0x0003_0004`, `0x0005_0006` in order.
- Full-queue drain: with the queue full and `ostream.rdy` pulsed high for one cycle → exactly one request leaves; `istream.rdy` is still low that cycle and high the next.
- Reset mid-pair:
  - Send 7, then assert `rst` → `ostream.val = 0`, `istream.rdy = 1` immediately.
  - After release, send 8, 12 → `0x0008_000C` (7 is lost) without the macro; `0x000C_0008` with it.
- Random streaming, with 0 or 3 cycles of source and sink delay: for 20 random pairs, the requests match the packed pairs in order. Chained into `hw_gcd_GcdUnit`, each output equals the reference gcd of its pair.
